t_pulse_gen: RTL and testbench

//   Upstream driver for the edge-triggered T flip-flop bank.

---
 rtl/t_pulse_gen_if.sv | 23 ++
 rtl/t_pulse_gen.sv | 107 ++++++++++
 tb/tb_t_pulse_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/t_pulse_gen_if.sv
// rtl/t_pulse_gen_if.sv - control/status bundle between a pulse-generator host and t_pulse_gen
interface t_pulse_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] burst_len;
    logic             T;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output start, stop, div, burst_len,
        input  T, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, div, burst_len,
        output T, busy, done, pulse_cnt
    );
endinterface

// File: rtl/t_pulse_gen.sv
// rtl/t_pulse_gen.sv - T-pulse generator (every div+1 clocks, continuous or burst) for a T flip-flop bank
// Optional TPG_PHASE_OUT_EN adds a phase output mirroring the downstream flip-flop Q.
module t_pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             rst,
    t_pulse_gen_if.slave     bus
`ifdef TPG_PHASE_OUT_EN
    ,
    output logic             phase
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_l, div_n;
    logic [CNT_W-1:0] bl_l, bl_n;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic             t_q, t_n;
    logic             done_q, done_n;
`ifdef TPG_PHASE_OUT_EN
    logic             phase_q, phase_n;
`endif

    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_l   <= '0;
            bl_l    <= '0;
            pcnt    <= '0;
            t_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef TPG_PHASE_OUT_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_l   <= div_n;
            bl_l    <= bl_n;
            pcnt    <= pcnt_n;
            t_q     <= t_n;
            done_q  <= done_n;
`ifdef TPG_PHASE_OUT_EN
            phase_q <= phase_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_l;
        bl_n    = bl_l;
        pcnt_n  = pcnt;
        t_n     = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    div_n   = bus.div;
                    bl_n    = bus.burst_len;
                    cnt_n   = bus.div;
                    pcnt_n  = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                end else if (cnt == '0) begin
                    t_n    = 1'b1;
                    cnt_n  = div_l;
                    pcnt_n = pcnt + 1'b1;
                    if (bl_l != '0 && pcnt_n == bl_l)
                        state_n = S_DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef TPG_PHASE_OUT_EN
    // follows the downstream flip-flop: flips on every edge that registers a T pulse
    always_comb begin
        phase_n = phase_q;
        if (t_n)
            phase_n = ~phase_q;
    end
    assign phase = phase_q;
`endif

    assign bus.T         = t_q;
    assign bus.busy      = (state == S_RUN);
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pcnt;
endmodule

// File: tb/tb_t_pulse_gen.sv
// tb/tb_t_pulse_gen.sv - directed self-checking bench for t_pulse_gen
module tb_t_pulse_gen;
    localparam int CNT_W = 8;

    logic CP;
    logic rst;
    int   tests_run;
    int   tests_failed;

    t_pulse_gen_if #(.CNT_W(CNT_W)) bus ();

`ifdef TPG_PHASE_OUT_EN
    logic phase;
    t_pulse_gen #(.CNT_W(CNT_W)) dut (.CP(CP), .rst(rst), .bus(bus), .phase(phase));
`else
    t_pulse_gen #(.CNT_W(CNT_W)) dut (.CP(CP), .rst(rst), .bus(bus));
`endif

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CP);
    endtask

    // leaves the bench at the negedge right after the start-accept edge E0
    task automatic do_start(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] b);
        bus.start     = 1'b1;
        bus.div       = d;
        bus.burst_len = b;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.div       = '0;
        bus.burst_len = '0;
        tick(2);
        check("rst_busy", bus.busy, 0);
        check("rst_T", bus.T, 0);
        check("rst_pcnt", bus.pulse_cnt, 0);
        rst = 1'b0;
        tick(1);

        // 1: async reset mid-run, div=3, while T is high
        do_start(8'd3, 8'd0);
        tick(8);
        check("t1_T_before", bus.T, 1);
        check("t1_pcnt_before", bus.pulse_cnt, 2);
        #1 rst = 1'b1;
        #1;
        check("t1_T", bus.T, 0);
        check("t1_busy", bus.busy, 0);
        check("t1_done", bus.done, 0);
        check("t1_pcnt", bus.pulse_cnt, 0);
`ifdef TPG_PHASE_OUT_EN
        check("t1_phase", phase, 0);
`endif
        tick(1);
        rst = 1'b0;
        tick(1);

        // 2: burst div=2 len=4 -> T at E0+3,6,9,12; done at E0+13
        do_start(8'd2, 8'd4);
        check("t2_busy_run", bus.busy, 1);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check($sformatf("t2_T_k%0d", k), bus.T, (k % 3 == 0 && k <= 12) ? 1 : 0);
            check($sformatf("t2_done_k%0d", k), bus.done, (k == 13) ? 1 : 0);
            if (k == 13) begin
                check("t2_pcnt", bus.pulse_cnt, 4);
                check("t2_busy_end", bus.busy, 0);
            end
        end

        // 3: div=0 continuous, wrap at 256, then stop
        do_start(8'd0, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("t3_T_k%0d", k), bus.T, 1);
        end
        check("t3_pcnt5", bus.pulse_cnt, 5);
        tick(251);
        check("t3_pcnt_wrap", bus.pulse_cnt, 0);
        check("t3_busy_wrap", bus.busy, 1);
        tick(1);
        check("t3_pcnt257", bus.pulse_cnt, 1);
        do_stop();
        check("t3_T_stop", bus.T, 0);
        check("t3_busy_stop", bus.busy, 0);
        check("t3_done_stop", bus.done, 0);
        check("t3_pcnt_hold", bus.pulse_cnt, 1);
        tick(1);
        check("t3_done_after", bus.done, 0);

        // 4: start+stop in IDLE ignored; start during RUN ignored
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.div   = 8'd5;
        tick(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("t4_busy_ss", bus.busy, 0);
        tick(1);
        check("t4_busy_ss2", bus.busy, 0);
        check("t4_pcnt_ss", bus.pulse_cnt, 1);
        do_start(8'd1, 8'd0);
        bus.start = 1'b1;
        bus.div   = 8'd7;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            bus.start = 1'b0;
            check($sformatf("t4_T_k%0d", k), bus.T, (k % 2 == 0) ? 1 : 0);
        end
        check("t4_pcnt", bus.pulse_cnt, 4);
        do_stop();
        check("t4_busy_stop", bus.busy, 0);

        // 5: single-pulse burst, then stop colliding with a due pulse
        do_start(8'd1, 8'd1);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check($sformatf("t5_T_k%0d", k), bus.T, (k == 2) ? 1 : 0);
            check($sformatf("t5_done_k%0d", k), bus.done, (k == 3) ? 1 : 0);
            if (k == 3) check("t5_pcnt", bus.pulse_cnt, 1);
        end
        do_start(8'd2, 8'd0);
        tick(2);
        do_stop();
        check("t5_T_stopdue", bus.T, 0);
        check("t5_busy_stopdue", bus.busy, 0);
        check("t5_pcnt_stopdue", bus.pulse_cnt, 0);
        tick(2);
        check("t5_T_idle", bus.T, 0);

`ifdef TPG_PHASE_OUT_EN
        // 6: phase follows downstream Q, div=1 -> flips every 2 cycles
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        do_start(8'd1, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check($sformatf("t6_phase_k%0d", k), phase, (k / 2) % 2);
        end
        do_stop();
        check("t6_phase_hold", phase, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
